// File: rtl/PixelSensorConfig.sv
// Default geometry of the pixel sensor array, shared by the readout logic.
package PixelSensorConfig;
    parameter int PIXEL_ARRAY_WIDTH  = 4;
    parameter int PIXEL_ARRAY_HEIGHT = 4;
    parameter int PIXEL_BITS         = 10;
endpackage

// File: rtl/pixel_row_readout.sv
// Frame readout sequencer: strobes one sensor row at a time, captures the shared
// row bus into a local buffer and streams that row's pixels over valid/ready.
//
// state   | meaning
// IDLE    | waiting for START
// SELECT  | ROW_READ[row] asserted, row bus settling
// CAPTURE | ROW_READ[row] still asserted, bus latched on exit
// STREAM  | buffered pixels offered one per transfer
// DONE    | one-cycle FRAME_DONE pulse
module pixel_row_readout #(
    parameter int PIXEL_ARRAY_WIDTH  = PixelSensorConfig::PIXEL_ARRAY_WIDTH,
    parameter int PIXEL_ARRAY_HEIGHT = PixelSensorConfig::PIXEL_ARRAY_HEIGHT,
    parameter int PIXEL_BITS         = PixelSensorConfig::PIXEL_BITS,
    localparam int X_W = (PIXEL_ARRAY_WIDTH  > 1) ? $clog2(PIXEL_ARRAY_WIDTH)  : 1,
    localparam int Y_W = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1
) (
    input  logic                                        CLK,
    input  logic                                        RESET_N,
    input  logic                                        START,
    input  logic                                        ABORT,
    input  logic [PIXEL_ARRAY_WIDTH-1:0][PIXEL_BITS-1:0] ROW_DATA,
    output logic [PIXEL_ARRAY_HEIGHT-1:0]               ROW_READ,
    output logic [PIXEL_BITS-1:0]                       PIXEL_OUT,
    output logic                                        PIXEL_VALID,
    input  logic                                        PIXEL_READY,
    output logic [X_W-1:0]                              PIXEL_X,
    output logic [Y_W-1:0]                              PIXEL_Y,
    output logic                                        BUSY,
    output logic                                        FRAME_DONE
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        CAPTURE = 3'd2,
        STREAM  = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [X_W-1:0] COL_LAST = X_W'(PIXEL_ARRAY_WIDTH - 1);
    localparam logic [Y_W-1:0] ROW_LAST = Y_W'(PIXEL_ARRAY_HEIGHT - 1);

    state_t                                       state_q, state_d;
    logic [Y_W-1:0]                               row_q, row_d;
    logic [X_W-1:0]                               col_q, col_d;
    logic [PIXEL_ARRAY_WIDTH-1:0][PIXEL_BITS-1:0] buf_q, buf_d;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        buf_d       = buf_q;
        ROW_READ    = '0;
        PIXEL_OUT   = '0;
        PIXEL_VALID = 1'b0;
        PIXEL_X     = '0;
        PIXEL_Y     = '0;
        BUSY        = (state_q != IDLE);
        FRAME_DONE  = (state_q == DONE);

        // Abort wins over everything, including a transfer in the same cycle.
        if (state_q != IDLE && ABORT) begin
            state_d = IDLE;
            row_d   = '0;
            col_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (START && !ABORT) begin
                        state_d = SELECT;
                        row_d   = '0;
                        col_d   = '0;
                    end
                end
                SELECT: state_d = CAPTURE;
                CAPTURE: begin
                    buf_d   = ROW_DATA;
                    state_d = STREAM;
                end
                STREAM: begin
                    if (PIXEL_READY) begin
                        if (col_q != COL_LAST) begin
                            col_d = col_q + X_W'(1);
                        end else begin
                            col_d = '0;
                            if (row_q != ROW_LAST) begin
                                row_d   = row_q + Y_W'(1);
                                state_d = SELECT;
                            end else begin
                                state_d = DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    row_d   = '0;
                    col_d   = '0;
                end
                default: state_d = IDLE;
            endcase
        end

        if (state_q == SELECT || state_q == CAPTURE) begin
            ROW_READ[row_q] = 1'b1;
        end
        if (state_q == STREAM) begin
            PIXEL_VALID = 1'b1;
            PIXEL_OUT   = buf_q[col_q];
            PIXEL_X     = col_q;
            PIXEL_Y     = row_q;
        end
    end

endmodule

// File: tb/tb_pixel_row_readout.sv
// Bench for pixel_row_readout on a 2x2, 8-bit array: a row-bus model answers the
// row strobes and a queue of expected pixels scores every accepted transfer.
module tb_pixel_row_readout;

    localparam int W = 2;
    localparam int H = 2;
    localparam int B = 8;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic                abort;
    logic [W-1:0][B-1:0] row_data;
    logic [H-1:0]        row_read;
    logic [B-1:0]        pixel_out;
    logic                pixel_valid;
    logic                pixel_ready;
    logic [0:0]          pixel_x;
    logic [0:0]          pixel_y;
    logic                busy;
    logic                frame_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] frame [0:H-1][0:W-1];

    typedef struct {
        int         x;
        int         y;
        logic [7:0] v;
    } pix_t;

    pixel_row_readout #(
        .PIXEL_ARRAY_WIDTH (W),
        .PIXEL_ARRAY_HEIGHT(H),
        .PIXEL_BITS        (B)
    ) dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .START      (start),
        .ABORT      (abort),
        .ROW_DATA   (row_data),
        .ROW_READ   (row_read),
        .PIXEL_OUT  (pixel_out),
        .PIXEL_VALID(pixel_valid),
        .PIXEL_READY(pixel_ready),
        .PIXEL_X    (pixel_x),
        .PIXEL_Y    (pixel_y),
        .BUSY       (busy),
        .FRAME_DONE (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Sensor rows drive the shared bus only while strobed; otherwise it floats high.
    always_comb begin
        row_data = '1;
        if (row_read == 2'b01) row_data = {frame[0][1], frame[0][0]};
        else if (row_read == 2'b10) row_data = {frame[1][1], frame[1][0]};
    end

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; pixel_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (row_read !== 2'b00) begin errors++; $display("FAIL reset_row_read: got %b want 00", row_read); end
        checks++; if (pixel_valid !== 1'b0 || pixel_out !== 8'h00) begin errors++; $display("FAIL reset_pixel: got v=%b d=%h want 0/00", pixel_valid, pixel_out); end
        checks++; if (pixel_x !== 1'b0 || pixel_y !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL reset_xy_done: got x=%b y=%b d=%b want 0", pixel_x, pixel_y, frame_done); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_wait_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_frame(input string name, input int ready_pct, input bit fixed_vals,
                              input bit stall_10, input bit start_mid);
        pix_t       exp_q[$];
        pix_t       head;
        pix_t       p;
        logic [H-1:0] exp_rr;
        logic [7:0] s_out;
        logic       s_x, s_y, rdy;
        bit         stalled;
        int         cyc, done_cnt, done_cyc, stall_left, held;

        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                frame[y][x] = fixed_vals ? 8'(8'h11 * (y * W + x + 1)) : 8'($urandom_range(0, 255));
                p.x = x; p.y = y; p.v = frame[y][x];
                exp_q.push_back(p);
            end
        end
        head = exp_q[0];
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1; done_cnt = 0; done_cyc = 0; stalled = 0; stall_left = 3; held = 0;
        s_out = '0; s_x = 0; s_y = 0;
        while (cyc <= 200) begin
            if (exp_q.size() != 0) head = exp_q[0];
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy: cyc %0d got %b want 1", name, cyc, busy); end
            exp_rr = '0;
            if (!pixel_valid && !frame_done && exp_q.size() != 0) exp_rr[head.y] = 1'b1;
            checks++; if (row_read !== exp_rr) begin errors++; $display("FAIL %s_row_read: cyc %0d got %b want %b", name, cyc, row_read, exp_rr); end
            if (stalled) begin
                held++;
                checks++;
                if (pixel_valid !== 1'b1 || pixel_out !== s_out || pixel_x !== s_x || pixel_y !== s_y) begin
                    errors++; $display("FAIL %s_hold: cyc %0d got v=%b d=%h (%b,%b) want 1 %h (%b,%b)", name, cyc, pixel_valid, pixel_out, pixel_x, pixel_y, s_out, s_x, s_y);
                end
            end
            if (pixel_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL %s_extra_pixel: cyc %0d got %h want none", name, cyc, pixel_out);
                end else if (pixel_out !== head.v || pixel_x !== 1'(head.x) || pixel_y !== 1'(head.y)) begin
                    errors++; $display("FAIL %s_pixel: cyc %0d got %h (%b,%b) want %h (%0d,%0d)", name, cyc, pixel_out, pixel_x, pixel_y, head.v, head.x, head.y);
                end
            end
            if (frame_done) begin
                done_cnt++; done_cyc = cyc;
                checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL %s_early_done: got %0d pixels left want 0", name, exp_q.size()); end
                break;
            end
            rdy = ($urandom_range(0, 99) < ready_pct);
            if (stall_10 && pixel_valid && head.x == 1 && head.y == 0 && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end
            pixel_ready = rdy;
            if (start_mid && pixel_valid) start = 1'($urandom_range(0, 1));
            stalled = pixel_valid && !rdy;
            s_out = pixel_out; s_x = pixel_x; s_y = pixel_y;
            if (pixel_valid && rdy && exp_q.size() != 0) void'(exp_q.pop_front());
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s_done_seen: got %0d want 1 (timeout)", name, done_cnt); end
        if (ready_pct == 100 && !stall_10) begin
            checks++; if (done_cyc != H * (W + 2) + 1) begin errors++; $display("FAIL %s_latency: got %0d want %0d", name, done_cyc, H * (W + 2) + 1); end
        end
        if (stall_10) begin
            checks++; if (held != 3 || done_cyc != H * (W + 2) + 4) begin errors++; $display("FAIL %s_stall: got held=%0d done=%0d want 3/%0d", name, held, done_cyc, H * (W + 2) + 4); end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL %s_after_done: got busy=%b done=%b want 0/0", name, busy, frame_done); end
        end
        pixel_ready = 1'b0;
    endtask

    task automatic test_abort_pixel01();
        int n;
        int dones;
        pixel_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0; dones = 0;
        while (!(pixel_valid && pixel_x == 1'b0 && pixel_y == 1'b1) && n < 50) begin
            @(negedge clk); n++;
        end
        checks++; if (n >= 50) begin errors++; $display("FAIL abort_reach: got timeout want pixel (0,1)"); end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checks++; if (busy !== 1'b0 || pixel_valid !== 1'b0 || frame_done !== 1'b0 || row_read !== 2'b00) begin
            errors++; $display("FAIL abort_idle: got busy=%b v=%b done=%b rr=%b want 0 0 0 00", busy, pixel_valid, frame_done, row_read);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (frame_done) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", dones); end
        pixel_ready = 1'b0;
    endtask

    task automatic test_abort_random();
        int k;
        for (int t = 0; t < 6; t++) begin
            k = $urandom_range(1, H * (W + 2));
            pixel_ready = 1'($urandom_range(0, 1));
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
            for (int i = 1; i < k; i++) @(negedge clk);
            abort = 1'b1;
            @(negedge clk); abort = 1'b0;
            checks++; if (busy !== 1'b0 || frame_done !== 1'b0 || row_read !== 2'b00 || pixel_valid !== 1'b0) begin
                errors++; $display("FAIL abort_rand_k%0d: got busy=%b done=%b rr=%b v=%b want 0 0 00 0", k, busy, frame_done, row_read, pixel_valid);
            end
        end
        pixel_ready = 1'b0;
    endtask

    task automatic test_start_abort_idle();
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0 || row_read !== 2'b00) begin errors++; $display("FAIL start_abort_idle: got busy=%b rr=%b want 0 00", busy, row_read); end
    endtask

    task automatic test_async_reset();
        int n;
        int dones;
        pixel_ready = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0; dones = 0;
        while (!pixel_valid && n < 20) begin @(negedge clk); n++; end
        checks++; if (!pixel_valid) begin errors++; $display("FAIL areset_reach: got valid=%b want 1", pixel_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pixel_valid !== 1'b0 || pixel_out !== 8'h00 || busy !== 1'b0 || row_read !== 2'b00) begin
            errors++; $display("FAIL areset_outputs: got v=%b d=%h busy=%b rr=%b want 0 00 0 00", pixel_valid, pixel_out, busy, row_read);
        end
        checks++; if (pixel_x !== 1'b0 || pixel_y !== 1'b0 || frame_done !== 1'b0) begin
            errors++; $display("FAIL areset_xy: got x=%b y=%b done=%b want 0 0 0", pixel_x, pixel_y, frame_done);
        end
        @(negedge clk); rst_n = 1'b1; pixel_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (frame_done || busy) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL areset_idle: got %0d active cycles want 0", dones); end
        pixel_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame("full_frame", 100, 1'b1, 1'b0, 1'b0);
        test_frame("backpressure", 100, 1'b1, 1'b1, 1'b0);
        test_frame("start_in_stream", 100, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) test_frame("random_ready", 60, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
        test_abort_pixel01();
        test_frame("restart_after_abort", 100, 1'b0, 1'b0, 1'b0);
        test_abort_random();
        test_start_abort_idle();
        test_async_reset();
        test_frame("after_async_reset", 70, 1'b0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_row_readout.md
PIXEL_ROW_READOUT -- requirements
Module: pixel_row_readout

Interface
REQ-001 The block SHALL have parameter PIXEL_ARRAY_WIDTH, default PixelSensorConfig::PIXEL_ARRAY_WIDTH, giving the pixels per row.
REQ-002 The block SHALL have parameter PIXEL_ARRAY_HEIGHT, default PixelSensorConfig::PIXEL_ARRAY_HEIGHT, giving the rows per frame.
REQ-003 The block SHALL have parameter PIXEL_BITS, default PixelSensorConfig::PIXEL_BITS, giving the bits per pixel.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port START, input, 1 bit: request one full-frame readout; sampled only in IDLE.
REQ-007 The block SHALL have port ABORT, input, 1 bit: synchronous cancel of a readout in progress.
REQ-008 The block SHALL have port ROW_DATA, input, [PIXEL_ARRAY_WIDTH-1:0][PIXEL_BITS-1:0]: shared data bus driven by the selected pixel row.
REQ-009 The block SHALL have port ROW_READ, output, [PIXEL_ARRAY_HEIGHT-1:0]: one-hot READ strobe per row.
REQ-010 The block SHALL have port PIXEL_OUT, output, [PIXEL_BITS-1:0]: streamed pixel value.
REQ-011 The block SHALL have port PIXEL_VALID, output, 1 bit, and port PIXEL_READY, input, 1 bit: the stream handshake.
REQ-012 The block SHALL have ports PIXEL_X and PIXEL_Y, outputs, $clog2 of width and of height respectively (minimum 1 bit each): column and row of PIXEL_OUT.
REQ-013 The block SHALL have port BUSY, output, 1 bit: high in any state other than IDLE.
REQ-014 The block SHALL have port FRAME_DONE, output, 1 bit: one-cycle pulse after the last pixel is accepted.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, SELECT, CAPTURE, STREAM and DONE.
REQ-016 In IDLE, START=1 SHALL move the FSM to SELECT with row=0 and col=0.
REQ-017 In SELECT and in CAPTURE, the FSM SHALL drive ROW_READ[row]=1 and all other ROW_READ bits 0; ROW_READ SHALL be all-zero in every other state.
REQ-018 SELECT SHALL move unconditionally to CAPTURE, giving the row bus one settle cycle.
REQ-019 At the clock edge that leaves CAPTURE, the FSM SHALL latch ROW_DATA into an internal row buffer and move to STREAM.
REQ-020 In STREAM, the block SHALL drive PIXEL_VALID=1, PIXEL_OUT=buffer[col], PIXEL_X=col and PIXEL_Y=row.
REQ-021 In STREAM, while PIXEL_READY=0, all stream outputs SHALL hold stable.
REQ-022 A transfer SHALL occur on a cycle with PIXEL_VALID=1 and PIXEL_READY=1; if col<PIXEL_ARRAY_WIDTH-1, col SHALL increment and the FSM SHALL stay in STREAM.
REQ-023 On a transfer with col=PIXEL_ARRAY_WIDTH-1 and row<PIXEL_ARRAY_HEIGHT-1, col SHALL wrap to 0, row SHALL increment, and the FSM SHALL move to SELECT.
REQ-024 On a transfer with col=PIXEL_ARRAY_WIDTH-1 and row=PIXEL_ARRAY_HEIGHT-1, the FSM SHALL move to DONE.
REQ-025 DONE SHALL assert FRAME_DONE=1 for exactly one cycle and then move to IDLE.
REQ-026 With PIXEL_READY held high, a frame SHALL take PIXEL_ARRAY_HEIGHT*(PIXEL_ARRAY_WIDTH+2)+1 cycles from the first SELECT cycle to the DONE cycle inclusive.
REQ-027 Outside STREAM, PIXEL_VALID SHALL be 0 and PIXEL_READY SHALL be ignored.
REQ-028 START asserted while BUSY=1 SHALL be ignored and SHALL not be queued.
REQ-029 ABORT=1 in any state other than IDLE SHALL force IDLE at the next edge and clear row and col, with no FRAME_DONE pulse.
REQ-030 ABORT SHALL take priority over a simultaneous transfer.
REQ-031 START and ABORT asserted together in IDLE SHALL leave the FSM in IDLE.

Reset
REQ-032 While RESET_N=0, the block SHALL hold state=IDLE, row=0, col=0, row buffer=0, ROW_READ=0, PIXEL_OUT=0, PIXEL_VALID=0, PIXEL_X=0, PIXEL_Y=0, BUSY=0 and FRAME_DONE=0, independent of CLK.
REQ-033 Reset asserted mid-frame SHALL abandon the frame immediately, with no FRAME_DONE pulse.
REQ-034 After reset is released, the block SHALL wait in IDLE for START.

Verification (2x2 array, 8-bit pixels)
REQ-035 Full frame, READY=1: row 0 bus {0x11,0x22} and row 1 bus {0x33,0x44}, START pulse -> ROW_READ=01 for 2 cycles, stream 0x11(0,0), 0x22(1,0), then ROW_READ=10 for 2 cycles, stream 0x33(0,1), 0x44(1,1), FRAME_DONE on the 9th cycle after the first SELECT cycle.
REQ-036 Backpressure: READY=0 for 3 cycles during pixel (1,0) -> PIXEL_OUT holds 0x22 and VALID=1 throughout, and the transfer occurs on the first READY=1 cycle.
REQ-037 Bus change after capture: ROW_DATA changes to 0xFF after CAPTURE -> streamed values remain the latched 0x11 and 0x22.
REQ-038 START during STREAM -> ignored, and exactly one FRAME_DONE pulse occurs.
REQ-039 ABORT at pixel (0,1) -> next cycle IDLE, VALID=0, no FRAME_DONE, and a new START restarts at (0,0).
REQ-040 RESET_N=0 asynchronously mid-STREAM -> all outputs go to 0 before the next CLK edge.
